// File: rtl/jtag_tx_pop_if.sv
// jtag_tx_pop_if
//   Groups the virtual-JTAG scan strobes, the host-facing tdo and the fabric
//   push port of the FPGA-to-host pop channel.
//   slave  : the pop channel itself (consumes strobes/pushes, drives tdo/status)
//   master : whoever drives the strobes and the push port (JTAG instance + fabric)
//   Signals: tdi, ir_in[2:0], cdr, sdr, udr, tdo,
//            in_data[DATA_W-1:0], in_valid, in_ready, level[AW:0], overflow, popped
interface jtag_tx_pop_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 4
);
  logic              tdi;
  logic [2:0]        ir_in;
  logic              cdr;
  logic              sdr;
  logic              udr;
  logic              tdo;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [AW:0]       level;
  logic              overflow;
  logic              popped;

  modport slave (
    input  tdi, ir_in, cdr, sdr, udr, in_data, in_valid,
    output tdo, in_ready, level, overflow, popped
  );

  modport master (
    output tdi, ir_in, cdr, sdr, udr, in_data, in_valid,
    input  tdo, in_ready, level, overflow, popped
  );
endinterface

// File: rtl/jtag_tx_pop.sv
// jtag_tx_pop
//   FPGA-to-host half of the virtual-JTAG data channel. Fabric pushes words
//   into a circular FIFO; the host drains one word per POP DR scan. A POP
//   capture loads {head, valid=1} (or all zeros when empty) LSB-first; the
//   following update removes the word. A STATUS capture loads {overflow, level}.
//   Ports:
//     tck     : JTAG clock, all logic on posedge
//     reset_n : asynchronous active-low reset
//     bus     : jtag_tx_pop_if.slave (scan strobes, tdo, push port, status)
module jtag_tx_pop #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic         tck,
  input  logic         reset_n,
  jtag_tx_pop_if.slave bus
);

  localparam logic [2:0]  IR_POP    = 3'b010;
  localparam logic [2:0]  IR_STATUS = 3'b011;
  localparam logic [AW:0] FULL_LVL  = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic [DATA_W:0]   shreg_q, shreg_d;
  logic              captured_q, captured_d;
  logic              overflow_q, overflow_d;
  logic              popped_q, popped_d;

  logic full, empty, push, pop, sel_pop, sel_status;

  assign full       = (level_q == FULL_LVL);
  assign empty      = (level_q == '0);
  assign sel_pop    = (bus.ir_in == IR_POP);
  assign sel_status = (bus.ir_in == IR_STATUS);
  // Acceptance uses the pre-edge level, so a pop on the same edge does not
  // open a slot for a push into a full FIFO.
  assign push       = bus.in_valid && !full;
  // captured guarantees the FIFO was non-empty at capture and no pop since.
  assign pop        = bus.udr && sel_pop && captured_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    shreg_d    = shreg_q;
    captured_d = captured_q;
    overflow_d = overflow_q | (bus.in_valid & full);
    popped_d   = pop;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    if (bus.cdr) begin
      // Any capture clears captured; only a non-empty POP capture re-arms it.
      captured_d = 1'b0;
      if (sel_pop) begin
        if (!empty) begin
          shreg_d    = {mem_q[rd_ptr_q], 1'b1};
          captured_d = 1'b1;
        end else begin
          shreg_d = '0;
        end
      end else if (sel_status) begin
        shreg_d          = '0;
        shreg_d[AW:0]    = level_q;
        shreg_d[AW+1]    = overflow_q;
      end
    end else begin
      if (bus.sdr && (sel_pop || sel_status)) shreg_d = {bus.tdi, shreg_q[DATA_W:1]};
      if (pop) captured_d = 1'b0;
    end
  end

  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      shreg_q    <= '0;
      captured_q <= 1'b0;
      overflow_q <= 1'b0;
      popped_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      shreg_q    <= shreg_d;
      captured_q <= captured_d;
      overflow_q <= overflow_d;
      popped_q   <= popped_d;
    end
  end

  // Storage needs no reset: contents are only observable behind the pointers.
  always_ff @(posedge tck) begin
    if (push) mem_q[wr_ptr_q] <= bus.in_data;
  end

  assign bus.tdo      = (sel_pop || sel_status) ? shreg_q[0] : bus.tdi;
  assign bus.in_ready = !full;
  assign bus.level    = level_q;
  assign bus.overflow = overflow_q;
  assign bus.popped   = popped_q;

endmodule

// File: tb/tb_jtag_tx_pop.sv
module tb_jtag_tx_pop;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;
  localparam logic [2:0] IR_POP    = 3'b010;
  localparam logic [2:0] IR_STATUS = 3'b011;

  logic tck = 1'b0;
  logic reset_n;

  jtag_tx_pop_if #(.DATA_W(DATA_W), .AW(AW)) bus ();

  jtag_tx_pop #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) dut (
    .tck     (tck),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 tck = ~tck;

  // Reference model: the FIFO contents as a plain queue plus the sticky flag.
  logic [DATA_W-1:0] q[$];
  bit                m_ovf;

  int n_checks = 0;
  int n_pass   = 0;
  int pop_cnt  = 0;

  always @(posedge tck) if (bus.popped === 1'b1) pop_cnt++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w);
    chk("in_ready", bus.in_ready, (q.size() < DEPTH));
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    tick();
    bus.in_valid = 1'b0;
    if (q.size() < DEPTH) q.push_back(w);
    else m_ovf = 1'b1;
  endtask

  task automatic do_cdr(input logic [2:0] ir);
    bus.ir_in = ir;
    bus.cdr   = 1'b1;
    tick();
    bus.cdr   = 1'b0;
  endtask

  // Shifts n bits, collecting tdo before each shift edge (LSB first).
  task automatic do_shift(input int n, output logic [DATA_W:0] rd);
    rd = '0;
    bus.sdr = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i <= DATA_W) rd[i] = bus.tdo;
      tick();
      bus.tdi = 1'($urandom);
    end
    bus.sdr = 1'b0;
  endtask

  task automatic do_udr(input bit push_too, input logic [DATA_W-1:0] w);
    bus.udr = 1'b1;
    if (push_too) begin
      bus.in_valid = 1'b1;
      bus.in_data  = w;
    end
    tick();
    bus.udr      = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic pop_scan(input string tag, input bit push_on_udr, input logic [DATA_W-1:0] w);
    logic [DATA_W:0] rd;
    logic [DATA_W:0] exp;
    bit nonempty;
    nonempty = (q.size() != 0);
    exp = nonempty ? {q[0], 1'b1} : '0;
    do_cdr(IR_POP);
    do_shift(DATA_W + 1, rd);
    chk({tag, "_data"}, rd, exp);
    do_udr(push_on_udr, w);
    chk({tag, "_popped"}, bus.popped, nonempty);
    if (nonempty) void'(q.pop_front());
    if (push_on_udr) begin
      // acceptance judged on pre-edge occupancy
      if (q.size() + (nonempty ? 1 : 0) < DEPTH) q.push_back(w);
      else m_ovf = 1'b1;
    end
    chk({tag, "_level"}, bus.level, q.size());
    chk({tag, "_ovf"}, bus.overflow, m_ovf);
  endtask

  task automatic status_scan(input string tag);
    logic [DATA_W:0] rd;
    logic [DATA_W:0] exp;
    exp = '0;
    exp[AW:0] = (AW+1)'(q.size());
    exp[AW+1] = m_ovf;
    do_cdr(IR_STATUS);
    do_shift(DATA_W + 1, rd);
    chk({tag, "_status"}, rd, exp);
    do_udr(1'b0, '0);
    chk({tag, "_nopop"}, bus.popped, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W:0] rd;
    logic [DATA_W-1:0] w;
    int pc0;

    reset_n      = 1'b0;
    bus.tdi      = 1'b0;
    bus.ir_in    = 3'b000;
    bus.cdr      = 1'b0;
    bus.sdr      = 1'b0;
    bus.udr      = 1'b0;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    m_ovf        = 1'b0;
    repeat (3) tick();
    chk("rst_level", bus.level, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_popped", bus.popped, 0);
    reset_n = 1'b1;
    tick();
    chk("rst_in_ready", bus.in_ready, 1);

    // Three words, three pops, then an empty scan.
    push_word(32'hA5A5_0001);
    push_word(32'h0000_0002);
    push_word(32'h8000_0003);
    chk("t1_level3", bus.level, 3);
    pop_scan("t1_p1", 1'b0, '0);
    pop_scan("t1_p2", 1'b0, '0);
    pop_scan("t1_p3", 1'b0, '0);
    pop_scan("t1_empty", 1'b0, '0);
    chk("t1_level0", bus.level, 0);

    // Overflow: 17 pushes into 16 slots.
    for (int i = 1; i <= 17; i++) push_word(32'h1000_0000 + i);
    chk("t2_in_ready", bus.in_ready, 0);
    chk("t2_ovf", bus.overflow, 1);
    chk("t2_level", bus.level, 16);
    status_scan("t2");
    pop_scan("t2_first", 1'b0, '0);
    while (q.size() > 0) pop_scan("t2_drain", 1'b0, '0);

    // Push on the pop's update edge with one word stored.
    push_word(32'hCAFE_0001);
    pop_scan("t3_same_edge", 1'b1, 32'hCAFE_0002);
    chk("t3_level1", bus.level, 1);
    pop_scan("t3_new", 1'b0, '0);

    // Push into full FIFO on the pop edge is rejected.
    for (int i = 0; i < DEPTH; i++) push_word(32'h2000_0000 + i);
    pop_scan("t3_full_edge", 1'b1, 32'hDEAD_BEEF);
    chk("t3_full_level", bus.level, DEPTH - 1);
    while (q.size() > 0) pop_scan("t3_drain", 1'b0, '0);

    // Re-capture without update: one pop, same head.
    push_word(32'h3333_0001);
    push_word(32'h3333_0002);
    pc0 = pop_cnt;
    do_cdr(IR_POP);
    do_shift(10, rd);
    do_cdr(IR_POP);
    do_shift(DATA_W + 1, rd);
    chk("t4_recap_data", rd, {q[0], 1'b1});
    do_udr(1'b0, '0);
    tick();
    chk("t4_one_pop", pop_cnt - pc0, 1);
    void'(q.pop_front());
    chk("t4_level", bus.level, q.size());
    pop_scan("t4_next", 1'b0, '0);

    // Reset in the middle of a shift with 5 words stored (overflow still set).
    for (int i = 0; i < 5; i++) push_word(32'h5500_0000 + i);
    pc0 = pop_cnt;
    do_cdr(IR_POP);
    do_shift(10, rd);
    bus.sdr = 1'b1;
    reset_n = 1'b0;
    #2;
    chk("t5_level", bus.level, 0);
    chk("t5_ovf", bus.overflow, 0);
    chk("t5_tdo", bus.tdo, 0);
    q.delete();
    m_ovf = 1'b0;
    tick();
    reset_n = 1'b1;
    do_shift(20, rd);
    do_udr(1'b0, '0);
    tick();
    chk("t5_no_pop", pop_cnt - pc0, 0);
    chk("t5_level_after", bus.level, 0);

    // Bypass: tdo mirrors tdi.
    push_word(32'h6600_0001);
    bus.ir_in = 3'b000;
    bus.sdr   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.tdi = (i != 1);
      #1;
      chk("t6_bypass", bus.tdo, (i != 1));
      tick();
    end
    bus.sdr = 1'b0;
    chk("t6_level", bus.level, q.size());
    pop_scan("t6_pop", 1'b0, '0);

    // Pointer wrap: 16 in, 10 out, 10 in, drain.
    for (int i = 0; i < 16; i++) push_word(32'h7700_0000 + i);
    for (int i = 0; i < 10; i++) pop_scan("t7_pop", 1'b0, '0);
    for (int i = 16; i < 26; i++) push_word(32'h7700_0000 + i);
    chk("t7_level", bus.level, 16);
    while (q.size() > 0) pop_scan("t7_drain", 1'b0, '0);

    // Randomized mix of bursts, pops, status and same-edge push/pop.
    for (int it = 0; it < 250; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        int n;
        n = $urandom_range(1, 6);
        for (int k = 0; k < n; k++) begin
          w = $urandom;
          push_word(w);
          if ($urandom_range(0, 2) == 0) tick();
        end
        chk("rnd_level", bus.level, q.size());
      end else if (r <= 7) begin
        pop_scan("rnd_pop", 1'b0, '0);
      end else if (r == 8) begin
        status_scan("rnd");
      end else begin
        w = $urandom;
        pop_scan("rnd_pushpop", 1'b1, w);
      end
    end
    while (q.size() > 0) pop_scan("rnd_drain", 1'b0, '0);
    pop_scan("rnd_final_empty", 1'b0, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
